// File: rtl/secand_pkg.sv
// rtl/secand_pkg.sv - shared types and default sizing for the SecAND scheduler
package secand_pkg;

  localparam int K_WIDTH_DEF  = 32;
  localparam int N_SHARES_DEF = 3;
  localparam int N_REQ_DEF    = 4;
  localparam int RANDNUM      = N_SHARES_DEF * (N_SHARES_DEF - 1);
  localparam int RNDWIDTH     = K_WIDTH_DEF * RANDNUM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/secand_sched_rr_arbiter.sv
// rtl/secand_sched_rr_arbiter.sv - round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  always_comb begin
    logic          found;
    int            j;
    logic [IW-1:0] jj;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!found && req_i[jj]) begin
        found     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/secand_sched.sv
// rtl/secand_sched.sv - shares one SecAND core among N_REQ requesters, one fresh rnd word per op
module secand_sched
  import secand_pkg::*;
#(
  parameter int K_WIDTH  = secand_pkg::K_WIDTH_DEF,
  parameter int N_SHARES = secand_pkg::N_SHARES_DEF,
  parameter int N_REQ    = secand_pkg::N_REQ_DEF,
  localparam int MASKW   = K_WIDTH * N_SHARES,
  localparam int RNDW    = K_WIDTH * N_SHARES * (N_SHARES - 1),
  localparam int IW      = secand_pkg::idx_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*MASKW-1:0] req_x,
  input  logic [N_REQ*MASKW-1:0] req_y,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [MASKW-1:0]       rsp_z,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [RNDW-1:0]        rnd_in,
  output logic                   core_dvld,
  output logic                   core_ena,
  output logic [MASKW-1:0]       core_x,
  output logic [MASKW-1:0]       core_y,
  output logic [RNDW-1:0]        core_rnd,
  input  logic [MASKW-1:0]       core_z,
  input  logic                   core_ovld,
  output logic                   busy,
  output logic                   err
);

  state_e            state_q;
  logic [IW-1:0]     grant_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     rr_ptr_d;
  logic [MASKW-1:0]  rsp_z_q;
  logic              err_q;
  logic [N_REQ-1:0]  win_oh;
  logic [IW-1:0]     win_idx;
  logic              issue;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx)
  );

  assign issue    = (state_q == IDLE) && ena && rnd_valid && (|req_valid);
  assign rr_ptr_d = (int'(grant_q) >= N_REQ - 1) ? '0 : grant_q + 1'b1;

  // Operands and randomness reach the core only in the issue cycle; zero otherwise.
  assign req_ready = issue ? win_oh : '0;
  assign rnd_ready = issue;
  assign core_dvld = issue;
  assign core_ena  = issue;
  assign core_x    = issue ? req_x[win_idx*MASKW +: MASKW] : '0;
  assign core_y    = issue ? req_y[win_idx*MASKW +: MASKW] : '0;
  assign core_rnd  = issue ? rnd_in : '0;

  assign rsp_valid = (state_q == RESP) ? (N_REQ'(1) << grant_q) : '0;
  assign rsp_z     = rsp_z_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      rsp_z_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            grant_q <= win_idx;
            state_q <= WAIT;
          end
        end
        // The core is fixed 1-cycle latency; a missing ovld is a protocol error, not a stall.
        WAIT: begin
          rsp_z_q <= core_z;
          if (!core_ovld) err_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
